// File: rtl/lab3_mem_pattern_master_if.sv
// Avalon-MM bus between the pattern master and the lab3 on-chip RAM s1 port.
// Fixed read latency 1, no waitrequest.
interface lab3_mem_pattern_master_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, chipselect,
        output write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect,
        input  write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/lab3_mem_pattern_master.sv
// Memory self-test master: fills a wrapped word range with seed+i,
// reads it back and records mismatch count and first failing word.
module lab3_mem_pattern_master #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 25000,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    lab3_mem_pattern_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [CNT_W-1:0]  r_err_count;
    logic [ADDR_W-1:0] r_first_addr;
    logic [DATA_W-1:0] r_first_data;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cs;
    logic              r_we;
    logic [3:0]        r_be;
    logic              r_clken;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_n;
    logic [DATA_W-1:0] r_seed;
    logic [CNT_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_rd_pat;
    logic              r_cmp_vld;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [DATA_W-1:0] r_cmp_exp;

    logic              w_last;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_reject;
    logic              w_zero;
    logic              w_mismatch;

    assign w_last     = (r_idx == r_n - 1'b1);
    assign w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
    assign w_reject   = (32'(base_addr) >= DEPTH_U) ||
                        (32'(word_count) > DEPTH_U);
    assign w_zero     = (word_count == '0);
    assign w_mismatch = r_cmp_vld && (bus.readdata != r_cmp_exp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cs         <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= 4'h0;
            r_clken      <= 1'b0;
            r_base       <= '0;
            r_n          <= '0;
            r_seed       <= '0;
            r_idx        <= '0;
            r_rd_pat     <= '0;
            r_cmp_vld    <= 1'b0;
            r_cmp_addr   <= '0;
            r_cmp_exp    <= '0;
        end else begin
            r_clken   <= 1'b1;
            r_cmp_vld <= 1'b0;

            // readdata belongs to the address presented one cycle earlier
            if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_err_count != '1)
                    r_err_count <= r_err_count + 1'b1;
                if (r_err_count == '0) begin
                    r_first_addr <= r_cmp_addr;
                    r_first_data <= bus.readdata;
                end
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base       <= base_addr;
                        r_n          <= word_count;
                        r_seed       <= seed;
                        r_busy       <= 1'b1;
                        r_error      <= w_reject;
                        r_err_count  <= '0;
                        r_first_addr <= '0;
                        r_first_data <= '0;
                        r_idx        <= '0;
                        if (w_reject || w_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WRITE;
                            r_cs    <= 1'b1;
                            r_we    <= 1'b1;
                            r_be    <= 4'hF;
                            r_addr  <= base_addr;
                            r_wdata <= seed;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_state  <= S_READ;
                        r_we     <= 1'b0;
                        r_wdata  <= '0;
                        r_idx    <= '0;
                        r_addr   <= r_base;
                        r_rd_pat <= r_seed;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_addr  <= w_addr_nxt;
                        r_wdata <= r_wdata + 1'b1;
                    end
                end
                S_READ: begin
                    r_cmp_vld  <= 1'b1;
                    r_cmp_addr <= r_addr;
                    r_cmp_exp  <= r_rd_pat;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_cs    <= 1'b0;
                        r_be    <= 4'h0;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_addr   <= w_addr_nxt;
                        r_rd_pat <= r_rd_pat + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_addr;
    assign first_err_data = r_first_data;

    assign bus.address    = r_addr;
    assign bus.byteenable = r_be;
    assign bus.chipselect = r_cs;
    assign bus.write      = r_we;
    assign bus.writedata  = r_wdata;
    assign bus.clken      = r_clken;

endmodule

// File: tb/tb_lab3_mem_pattern_master.sv
// Directed bench for lab3_mem_pattern_master with a latency-1 RAM model
// that can corrupt one read address.
module tb_lab3_mem_pattern_master;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 25000;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              busy, done, error;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;

    lab3_mem_pattern_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lab3_mem_pattern_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .word_count(word_count), .seed(seed),
        .busy(busy), .done(done), .error(error),
        .err_count(err_count),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              fault_en = 1'b0;
    logic [ADDR_W-1:0] fault_addr = '0;
    logic [DATA_W-1:0] fault_val = '0;
    int                wr_a[$];
    logic [DATA_W-1:0] wr_d[$];
    int                rd_a[$];
    int                cs_cnt = 0;

    initial bus.readdata = '0;

    always @(posedge clk) begin
        if (bus.chipselect) begin
            cs_cnt <= cs_cnt + 1;
            if (bus.write) begin
                mem[bus.address] <= bus.writedata;
                wr_a.push_back(int'(bus.address));
                wr_d.push_back(bus.writedata);
            end else begin
                rd_a.push_back(int'(bus.address));
                if (fault_en && bus.address == fault_addr)
                    bus.readdata <= fault_val;
                else
                    bus.readdata <= mem[bus.address];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts a run and returns the cycle (relative to the start edge)
    // in which done is seen; optionally pulses a stray start at pulse_k.
    task automatic run(input int b, input int n, input logic [31:0] s,
                       input int pulse_k, output int done_k);
        bit busy_ok = 1'b1;
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        cs_cnt = 0;
        done_k = -1;
        @(negedge clk);
        base_addr  = ADDR_W'(b);
        word_count = CNT_W'(n);
        seed       = s;
        start      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == pulse_k) begin
                start = 1'b1;
                seed  = 32'hDEAD0000;
                base_addr = '0;
                word_count = 16'd1;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_k = k;
                break;
            end
        end
        chk("timeout", 64'(done_k > 0), 64'd1);
        chk("busy_in_run", 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    int dk;
    logic [31:0] exp_d;

    initial begin
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_errcnt", 64'(err_count), 64'd0);
        chk("rst_ferr_a", 64'(first_err_addr), 64'd0);
        chk("rst_ferr_d", 64'(first_err_data), 64'd0);
        chk("rst_cs", 64'(bus.chipselect), 64'd0);
        chk("rst_we", 64'(bus.write), 64'd0);
        chk("rst_be", 64'(bus.byteenable), 64'd0);
        chk("rst_clken", 64'(bus.clken), 64'd0);
        chk("rst_addr", 64'(bus.address), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("clken_on", 64'(bus.clken), 64'd1);

        // Clean run at base 0
        run(0, 4, 32'h1000, 0, dk);
        chk("t1_done_k", 64'(dk), 64'd10);
        chk("t1_nwr", 64'(wr_a.size()), 64'd4);
        chk("t1_nrd", 64'(rd_a.size()), 64'd4);
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            chk("t1_wr_a", 64'(wr_a[i]), 64'(i));
            chk("t1_wr_d", 64'(wr_d[i]), 64'(32'h1000 + i));
        end
        for (int i = 0; i < 4 && i < rd_a.size(); i++)
            chk("t1_rd_a", 64'(rd_a[i]), 64'(i));
        chk("t1_error", 64'(error), 64'd0);
        chk("t1_errcnt", 64'(err_count), 64'd0);

        // Same run, RAM returns wrong word at address 2
        fault_en = 1'b1; fault_addr = 15'd2; fault_val = 32'h1003;
        run(0, 4, 32'h1000, 0, dk);
        fault_en = 1'b0;
        chk("t2_done_k", 64'(dk), 64'd10);
        chk("t2_errcnt", 64'(err_count), 64'd1);
        chk("t2_ferr_a", 64'(first_err_addr), 64'd2);
        chk("t2_ferr_d", 64'(first_err_data), 64'h1003);
        chk("t2_error", 64'(error), 64'd1);
        @(negedge clk);
        chk("t2_err_held", 64'(error), 64'd1);

        // Wrap across the top of RAM and across 2^32
        run(24998, 4, 32'hFFFF_FFFE, 0, dk);
        chk("t3_done_k", 64'(dk), 64'd10);
        chk("t3_nwr", 64'(wr_a.size()), 64'd4);
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            chk("t3_wr_a", 64'(wr_a[i]), 64'((24998 + i) % DEPTH));
            exp_d = 32'hFFFF_FFFE + 32'(i);
            chk("t3_wr_d", 64'(wr_d[i]), 64'(exp_d));
        end
        chk("t3_error", 64'(error), 64'd0);
        chk("t3_errcnt", 64'(err_count), 64'd0);

        // Zero-length and rejected runs
        run(5, 0, 32'h1, 0, dk);
        chk("t4_zero_k", 64'(dk), 64'd1);
        chk("t4_zero_cs", 64'(cs_cnt), 64'd0);
        chk("t4_zero_err", 64'(error), 64'd0);
        run(25000, 4, 32'h1, 0, dk);
        chk("t4_rej_k", 64'(dk), 64'd1);
        chk("t4_rej_cs", 64'(cs_cnt), 64'd0);
        chk("t4_rej_err", 64'(error), 64'd1);
        chk("t4_rej_cnt", 64'(err_count), 64'd0);
        run(0, 25001, 32'h1, 0, dk);
        chk("t4_rej2_k", 64'(dk), 64'd1);
        chk("t4_rej2_err", 64'(error), 64'd1);

        // Asynchronous reset in the middle of WRITE
        @(negedge clk);
        base_addr = 15'd100; word_count = 16'd8; seed = 32'h55;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_cs_before", 64'(bus.chipselect), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_cs_rst", 64'(bus.chipselect), 64'd0);
        chk("t5_we_rst", 64'(bus.write), 64'd0);
        chk("t5_busy_rst", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run(10, 3, 32'hA0, 0, dk);
        chk("t5_done_k", 64'(dk), 64'd8);
        chk("t5_error", 64'(error), 64'd0);

        // Stray start during READ must be ignored
        run(200, 4, 32'h7700, 6, dk);
        chk("t6_done_k", 64'(dk), 64'd10);
        chk("t6_nwr", 64'(wr_a.size()), 64'd4);
        if (wr_d.size() == 4)
            chk("t6_wr_d3", 64'(wr_d[3]), 64'h7703);
        chk("t6_error", 64'(error), 64'd0);
        chk("t6_errcnt", 64'(err_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lab3_mem_pattern_master.md
# lab3_mem_pattern_master

Avalon-MM master that drives the single-port on-chip RAM slave in the lab3 Qsys system: it fills a word range with a deterministic pattern, reads the range back, and reports mismatches. It connects directly to the RAM's s1 port (32-bit data, 15-bit word address, 4-bit byteenable, no waitrequest, fixed read latency 1). It is used for power-on memory self-test and for fault-injection checks in simulation.

## Interface
Parameters:
- ADDR_W, 15, word-address width (matches RAM widthad)
- DATA_W, 32, data width
- DEPTH, 25000, number of valid RAM words
- CNT_W, 16, width of word_count / err_count

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE only
- base_addr  in  ADDR_W  first word address, sampled with start
- word_count  in  CNT_W  words to test, sampled with start
- seed  in  DATA_W  pattern seed, sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of run
- error  out  1  run had ≥1 mismatch or was rejected; held until next accepted start
- err_count  out  CNT_W  mismatch count, saturates at all-ones
- first_err_addr  out  ADDR_W  address of first mismatch
- first_err_data  out  DATA_W  readdata at first mismatch
- address  out  ADDR_W  to RAM
- byteenable  out  4  to RAM; constant 4'hF when chipselect high, else 0
- chipselect  out  1  to RAM
- write  out  1  to RAM
- writedata  out  DATA_W  to RAM
- clken  out  1  to RAM; 1 except during reset
- readdata  in  DATA_W  from RAM, valid the cycle after a read address is presented

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: bus idle (chipselect=0, write=0). On start=1: latch inputs, clear error/err_count/first_err_*.
  - base_addr ≥ DEPTH or word_count > DEPTH: rejected -> DONE with error=1, no bus traffic.
  - word_count = 0 -> DONE, error=0, no bus traffic.
  - else -> WRITE, index i=0.
- Word i: address = base+i, wrapped to base+i−DEPTH when ≥ DEPTH; pattern = seed + i mod 2^DATA_W.
- WRITE: one write per cycle, chipselect=1, write=1, writedata=pattern(i). After i=N−1 -> READ, i=0.
- READ: one read per cycle, chipselect=1, write=0. Expected value and address pipelined one stage. After i=N−1 -> DRAIN.
- Compare: in the cycle after each read address (READ cycles 2..N and DRAIN), readdata vs expected; on mismatch err_count+=1 (saturating), error=1, first_err_* captured only if err_count was 0.
- DRAIN: bus idle, final compare -> DONE.
- DONE: done=1 one cycle -> IDLE.
- start while busy: ignored. Latched inputs unchanged.

## Timing
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, error=0, err_count=0, first_err_addr=0, first_err_data=0, address=0, writedata=0, chipselect=0, write=0, byteenable=0, clken=0. clken=1 from first clock after reset deassertion. Reset mid-run aborts immediately; RAM contents undefined.
- Start sampled at edge t0 (N ≥ 1, valid): writes in cycles t0+1..t0+N, read addresses in t0+N+1..t0+2N, DRAIN at t0+2N+1, done at t0+2N+2; busy high t0+1..t0+2N+2.
- Zero-length or rejected run: done at t0+1, busy high t0+1 only.
- Bus outputs are registered; no combinational path from readdata to any output except via registered status.
- Back-to-back: next start accepted in the first IDLE cycle after DONE.

## Test plan
- base=0, N=4, seed=0x1000 with RAM model -> writes 0x1000..0x1003 to addr 0..3, reads same, done at t0+10, error=0, err_count=0.
- Same run, model returns 0x1003 at addr 2 -> err_count=1, first_err_addr=2, first_err_data=0x1003, error=1.
- base=24998, N=4, seed=0xFFFFFFFE -> addresses 24998,24999,0,1; data 0xFFFFFFFE,0xFFFFFFFF,0,1; error=0.
- word_count=0 -> done at t0+1, no chipselect; base_addr=25000 -> done at t0+1, error=1, err_count=0.
- reset_n low at t0+3 mid-WRITE -> chipselect/write/busy 0 asynchronously; fresh start after release completes normally.
- start pulsed during READ with different seed -> ignored; run completes with original seed, error=0.
